// File: rtl/pc_gen_pkg.sv
// Shared constants and types for the program-counter generator:
// MIPS opcode/func/rt encodings used by the branch and jump decode, and the FSM state type.
package pc_gen_pkg;

    localparam logic [5:0] SPECIAL = 6'b000000;
    localparam logic [5:0] REGIMM  = 6'b000001;
    localparam logic [5:0] J       = 6'b000010;
    localparam logic [5:0] JAL     = 6'b000011;
    localparam logic [5:0] BEQ     = 6'b000100;
    localparam logic [5:0] BNE     = 6'b000101;
    localparam logic [5:0] BLEZ    = 6'b000110;
    localparam logic [5:0] BGTZ    = 6'b000111;

    localparam logic [5:0] JR      = 6'b001000;
    localparam logic [5:0] JALR    = 6'b001001;

    localparam logic [4:0] BLTZ    = 5'b00000;
    localparam logic [4:0] BGEZ    = 5'b00001;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        TRAP
    } state_e;

endpackage

// File: rtl/pc_gen_if.sv
// Decode-side and fetch-side signals of pc_gen. The slave modport is the PC generator;
// the master modport is the decoder/fetch environment that drives it.
interface pc_gen_if #(
    parameter int unsigned PC_W   = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
);

    logic [5:0]        op;
    logic [5:0]        func;
    logic [4:0]        rt;
    logic [IMM_W-1:0]  imm;
    logic [25:0]       target;
    logic [DATA_W-1:0] rs_data;
    logic              zero;
    logic              branch;
    logic              jump;
    logic              instr_valid;
    logic              imem_ready;
    logic              stall;
    logic              trap_req;

    logic [PC_W-1:0]   pc;
    logic              pc_valid;
    logic [PC_W-1:0]   link_pc;
    logic              taken;
    logic              trap_ack;
    logic [PC_W-1:0]   epc;
    logic              epc_bd;

    modport master (
        output op, func, rt, imm, target, rs_data, zero, branch, jump,
        output instr_valid, imem_ready, stall, trap_req,
        input  pc, pc_valid, link_pc, taken, trap_ack, epc, epc_bd
    );

    modport slave (
        input  op, func, rt, imm, target, rs_data, zero, branch, jump,
        input  instr_valid, imem_ready, stall, trap_req,
        output pc, pc_valid, link_pc, taken, trap_ack, epc, epc_bd
    );

endinterface

// File: rtl/pc_target_calc.sv
// Purely combinational branch/jump resolution: evaluates the condition for the instruction
// at pc and returns whether it redirects plus the next address (seq when not taken).
module pc_target_calc
    import pc_gen_pkg::*;
#(
    parameter int unsigned PC_W   = 30,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IMM_W  = 16
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [4:0]        rt,
    input  logic [IMM_W-1:0]  imm,
    input  logic [25:0]       target,
    input  logic [DATA_W-1:0] rs_data,
    input  logic              zero,
    input  logic              branch,
    input  logic              jump,
    input  logic              enable,
    output logic              taken,
    output logic [PC_W-1:0]   next_pc
);

    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] bt;
    logic [PC_W-1:0] jt;
    logic [PC_W-1:0] rt_pc;
    logic            rs_neg;
    logic            rs_zero;
    logic            cond;
    logic            is_jr;

    assign seq     = pc + PC_W'(1);
    assign bt      = seq + {{(PC_W - IMM_W){imm[IMM_W-1]}}, imm};
    assign jt      = {seq[PC_W-1:26], target};
    assign rt_pc   = rs_data[PC_W+1:2];
    assign rs_neg  = rs_data[DATA_W-1];
    assign rs_zero = (rs_data == '0);
    assign is_jr   = (op == SPECIAL) && ((func == JR) || (func == JALR));

    always_comb begin
        cond = 1'b0;
        case (op)
            BEQ:     cond = zero;
            BNE:     cond = !zero;
            BLEZ:    cond = rs_zero || rs_neg;
            BGTZ:    cond = !rs_zero && !rs_neg;
            REGIMM: begin
                if (rt == BGEZ) begin
                    cond = !rs_neg;
                end else if (rt == BLTZ) begin
                    cond = rs_neg;
                end
            end
            default: cond = 1'b0;
        endcase
    end

    // Register jumps win over the decoder's jump flag, which wins over branches.
    always_comb begin
        taken   = 1'b0;
        next_pc = seq;
        if (enable) begin
            if (is_jr) begin
                taken   = 1'b1;
                next_pc = rt_pc;
            end else if (jump) begin
                taken   = 1'b1;
                next_pc = jt;
            end else if (branch && cond) begin
                taken   = 1'b1;
                next_pc = bt;
            end
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Registered program-counter generator: BOOT/RUN/TRAP FSM, pc, epc and stall handling.
// Define PC_GEN_DELAY_SLOT_EN to enable the MIPS branch delay slot (pending redirect register).
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     PC_W      = 30,
    parameter int unsigned     DATA_W    = 32,
    parameter int unsigned     IMM_W     = 16,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h20)
) (
    input logic      clk,
    input logic      rst,
    pc_gen_if.slave  bus
);

    state_e          state;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] epc_q;
    logic            pc_valid_q;
    logic            trap_ack_q;
    logic [PC_W-1:0] seq;
    logic [PC_W-1:0] next_pc;
    logic            calc_en;
    logic            calc_taken;
    logic            in_slot;
    logic            commit;

    assign seq     = pc_q + PC_W'(1);
    assign commit  = (state == RUN) && bus.instr_valid && bus.imem_ready && !bus.stall
                     && !bus.trap_req;
    assign calc_en = (state == RUN) && bus.instr_valid && !in_slot;

    pc_target_calc #(
        .PC_W   (PC_W),
        .DATA_W (DATA_W),
        .IMM_W  (IMM_W)
    ) u_calc (
        .pc      (pc_q),
        .op      (bus.op),
        .func    (bus.func),
        .rt      (bus.rt),
        .imm     (bus.imm),
        .target  (bus.target),
        .rs_data (bus.rs_data),
        .zero    (bus.zero),
        .branch  (bus.branch),
        .jump    (bus.jump),
        .enable  (calc_en),
        .taken   (calc_taken),
        .next_pc (next_pc)
    );

`ifdef PC_GEN_DELAY_SLOT_EN
    logic            pend_q;
    logic [PC_W-1:0] pend_tgt_q;
    logic [PC_W-1:0] pend_bpc_q;
    logic            epc_bd_q;

    // While a redirect is pending, the instruction at pc is the delay slot.
    assign in_slot     = pend_q;
    assign bus.link_pc = pc_q + PC_W'(2);
    assign bus.epc_bd  = epc_bd_q;
`else
    assign in_slot     = 1'b0;
    assign bus.link_pc = seq;
    assign bus.epc_bd  = 1'b0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.taken    = calc_taken;
    assign bus.trap_ack = trap_ack_q;
    assign bus.epc      = epc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BOOT;
            pc_q       <= RESET_VEC;
            pc_valid_q <= 1'b0;
            trap_ack_q <= 1'b0;
            epc_q      <= '0;
`ifdef PC_GEN_DELAY_SLOT_EN
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            pend_bpc_q <= '0;
            epc_bd_q   <= 1'b0;
`endif
        end else begin
            trap_ack_q <= 1'b0;
            unique case (state)
                BOOT: begin
                    state      <= RUN;
                    pc_valid_q <= 1'b1;
                end
                RUN: begin
                    if (bus.trap_req) begin
                        state      <= TRAP;
                        pc_valid_q <= 1'b0;
                        trap_ack_q <= 1'b1;
`ifdef PC_GEN_DELAY_SLOT_EN
                        // A trapped slot reports the branch so the handler can replay it.
                        epc_q      <= pend_q ? pend_bpc_q : pc_q;
                        epc_bd_q   <= pend_q;
                        pend_q     <= 1'b0;
`else
                        epc_q      <= pc_q;
`endif
                    end else if (commit) begin
`ifdef PC_GEN_DELAY_SLOT_EN
                        if (pend_q) begin
                            pc_q   <= pend_tgt_q;
                            pend_q <= 1'b0;
                        end else begin
                            pc_q <= seq;
                            if (calc_taken) begin
                                pend_q     <= 1'b1;
                                pend_tgt_q <= next_pc;
                                pend_bpc_q <= pc_q;
                            end
                        end
`else
                        pc_q <= next_pc;
`endif
                    end
                end
                TRAP: begin
                    state      <= RUN;
                    pc_q       <= TRAP_VEC;
                    pc_valid_q <= 1'b1;
                end
                default: begin
                    state      <= BOOT;
                    pc_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios plus a randomized run against a
// behavioural next-pc model. Honours PC_GEN_DELAY_SLOT_EN when defined.
module tb_pc_gen;
    import pc_gen_pkg::*;

    localparam int unsigned     PC_W   = 30;
    localparam int unsigned     DATA_W = 32;
    localparam int unsigned     IMM_W  = 16;
    localparam logic [PC_W-1:0] TVEC   = 30'h20;
`ifdef PC_GEN_DELAY_SLOT_EN
    localparam int LINK_INC = 2;
`else
    localparam int LINK_INC = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.PC_W(PC_W), .DATA_W(DATA_W), .IMM_W(IMM_W)) bus ();

    pc_gen #(
        .PC_W      (PC_W),
        .DATA_W    (DATA_W),
        .IMM_W     (IMM_W),
        .RESET_VEC ('0),
        .TRAP_VEC  (TVEC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.op = 6'b100011; bus.func = 6'd0; bus.rt = 5'd0; bus.imm = '0; bus.target = '0;
        bus.rs_data = '0; bus.zero = 1'b0; bus.branch = 1'b0; bus.jump = 1'b0;
        bus.instr_valid = 1'b1; bus.imem_ready = 1'b1; bus.stall = 1'b0; bus.trap_req = 1'b0;
    endtask

    task automatic goto(input logic [PC_W-1:0] addr);
        idle();
        bus.op = SPECIAL; bus.func = JR; bus.rs_data = {addr, 2'b00};
        tick();
`ifdef PC_GEN_DELAY_SLOT_EN
        idle();
        tick();
`endif
        idle();
        checks++;
        if (bus.pc !== addr) begin errors++; $display("FAIL goto: pc=%0h want %0h", bus.pc, addr); end
    endtask

    task automatic ds_slot(input logic [PC_W-1:0] slot_pc);
`ifdef PC_GEN_DELAY_SLOT_EN
        checks++;
        if (bus.pc !== slot_pc) begin
            errors++; $display("FAIL slot_pc: pc=%0h want %0h", bus.pc, slot_pc);
        end
        idle();
        tick();
`endif
    endtask

    task automatic test_reset();
        idle();
        bus.jump = 1'b1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (bus.pc !== '0) begin errors++; $display("FAIL rst_pc: got %0h want 0", bus.pc); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", bus.pc_valid); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL rst_taken: got %b want 0", bus.taken); end
        if (bus.trap_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b want 0", bus.trap_ack); end
        if (bus.epc_bd !== 1'b0) begin errors++; $display("FAIL rst_bd: got %b want 0", bus.epc_bd); end
        rst = 1'b0;
        #1;
        checks += 2;
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL boot_valid: got %b want 0", bus.pc_valid); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL boot_taken: got %b want 0", bus.taken); end
        idle();
        tick();
        checks += 2;
        if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL run_valid: got %b want 1", bus.pc_valid); end
        if (bus.pc !== 30'd0) begin errors++; $display("FAIL run_pc0: got %0h want 0", bus.pc); end
        for (int i = 1; i <= 2; i++) begin
            tick();
            checks++;
            if (bus.pc !== PC_W'(i)) begin errors++; $display("FAIL seq_pc: got %0h want %0h", bus.pc, i); end
        end
    endtask

    task automatic test_beq();
        goto(30'd10);
        bus.op = BEQ; bus.branch = 1'b1; bus.zero = 1'b1; bus.imm = 16'hFFFC;
        #1;
        checks++;
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL beq_taken: got %b want 1", bus.taken); end
        tick();
        ds_slot(30'd11);
        checks++;
        if (bus.pc !== 30'd7) begin errors++; $display("FAIL beq_back: pc=%0h want 7", bus.pc); end
        goto(30'd10);
        bus.op = BEQ; bus.branch = 1'b1; bus.zero = 1'b0; bus.imm = 16'hFFFC;
        #1;
        checks++;
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL beq_nt_taken: got %b want 0", bus.taken); end
        tick();
        checks++;
        if (bus.pc !== 30'd11) begin errors++; $display("FAIL beq_nt: pc=%0h want b", bus.pc); end
    endtask

    task automatic test_jr();
        goto(30'd10);
        bus.op = SPECIAL; bus.func = JALR; bus.rs_data = 32'h0000_0100;
        #1;
        checks += 2;
        if (bus.taken !== 1'b1) begin errors++; $display("FAIL jalr_taken: got %b want 1", bus.taken); end
        if (bus.link_pc !== PC_W'(10 + LINK_INC)) begin
            errors++; $display("FAIL jalr_link: got %0h want %0h", bus.link_pc, 10 + LINK_INC);
        end
        tick();
        ds_slot(30'd11);
        checks++;
        if (bus.pc !== 30'h40) begin errors++; $display("FAIL jalr_pc: pc=%0h want 40", bus.pc); end
    endtask

    task automatic test_stall();
        logic [IMM_W-1:0] im;
        logic [PC_W-1:0]  want;
        im   = IMM_W'($urandom);
        want = 30'd11 + PC_W'(int'($signed(im)));
        goto(30'd10);
        bus.op = BGTZ; bus.branch = 1'b1; bus.rs_data = 32'd5; bus.imm = im; bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) begin bus.stall = 1'b0; bus.imem_ready = 1'b0; end
            #1;
            checks++;
            if (bus.taken !== 1'b1) begin errors++; $display("FAIL hold_taken: got %b want 1", bus.taken); end
            tick();
            checks++;
            if (bus.pc !== 30'd10) begin errors++; $display("FAIL hold_pc: pc=%0h want a", bus.pc); end
        end
        bus.imem_ready = 1'b1;
        tick();
        ds_slot(30'd11);
        checks++;
        if (bus.pc !== want) begin errors++; $display("FAIL bgtz_pc: pc=%0h want %0h", bus.pc, want); end
    endtask

    task automatic test_trap();
        goto(30'h55);
        bus.jump = 1'b1; bus.target = 26'h3;
        bus.trap_req = 1'b1;
        tick();
        checks += 5;
        if (bus.trap_ack !== 1'b1) begin errors++; $display("FAIL trap_ack: got %b want 1", bus.trap_ack); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL trap_valid: got %b want 0", bus.pc_valid); end
        if (bus.epc !== 30'h55) begin errors++; $display("FAIL trap_epc: got %0h want 55", bus.epc); end
        if (bus.epc_bd !== 1'b0) begin errors++; $display("FAIL trap_bd: got %b want 0", bus.epc_bd); end
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL trap_taken: got %b want 0", bus.taken); end
        idle();
        tick();
        checks += 3;
        if (bus.trap_ack !== 1'b0) begin errors++; $display("FAIL ack_pulse: got %b want 0", bus.trap_ack); end
        if (bus.pc !== TVEC) begin errors++; $display("FAIL trap_vec: pc=%0h want 20", bus.pc); end
        if (bus.pc_valid !== 1'b1) begin errors++; $display("FAIL vec_valid: got %b want 1", bus.pc_valid); end
        tick();
        checks++;
        if (bus.pc !== 30'h21) begin errors++; $display("FAIL after_vec: pc=%0h want 21", bus.pc); end
    endtask

`ifdef PC_GEN_DELAY_SLOT_EN
    task automatic test_delay_slot();
        goto(30'd10);
        bus.op = BEQ; bus.branch = 1'b1; bus.zero = 1'b1; bus.imm = 16'd4;
        tick();
        checks++;
        if (bus.pc !== 30'd11) begin errors++; $display("FAIL ds_slot: pc=%0h want b", bus.pc); end
        idle();
        bus.jump = 1'b1; bus.target = 26'h123;
        #1;
        checks++;
        if (bus.taken !== 1'b0) begin errors++; $display("FAIL ds_slot_taken: got %b want 0", bus.taken); end
        tick();
        checks++;
        if (bus.pc !== 30'd15) begin errors++; $display("FAIL ds_target: pc=%0h want f", bus.pc); end
        goto(30'd10);
        bus.op = BEQ; bus.branch = 1'b1; bus.zero = 1'b1; bus.imm = 16'd4;
        tick();
        idle();
        bus.trap_req = 1'b1;
        tick();
        checks += 2;
        if (bus.epc !== 30'd10) begin errors++; $display("FAIL ds_epc: got %0h want a", bus.epc); end
        if (bus.epc_bd !== 1'b1) begin errors++; $display("FAIL ds_bd: got %b want 1", bus.epc_bd); end
        idle();
        tick();
        tick();
        checks++;
        if (bus.pc !== 30'h21) begin errors++; $display("FAIL ds_drop: pc=%0h want 21", bus.pc); end
    endtask
`endif

    task automatic test_random();
        logic [PC_W-1:0] m_pc, m_epc, m_pend_tgt, m_pend_bpc, seq, tgt;
        bit              m_trap, m_pend, m_bd, m_epc_known, cond, exp_taken;
        int              k, sel, off;
        goto(30'h1234);
        m_pc = 30'h1234; m_trap = 0; m_pend = 0; m_bd = 0; m_epc_known = 0;
        m_epc = '0; m_pend_tgt = '0; m_pend_bpc = '0;
        for (int i = 0; i < 400; i++) begin
            k   = $urandom_range(0, 8);
            sel = $urandom_range(0, 3);
            bus.func   = 6'($urandom);
            bus.rt     = 5'($urandom_range(0, 2));
            bus.imm    = IMM_W'($urandom);
            bus.target = 26'($urandom);
            bus.zero   = 1'($urandom);
            case (sel)
                0:       bus.rs_data = '0;
                1:       bus.rs_data = $urandom;
                2:       bus.rs_data = 32'h8000_0000 | $urandom;
                default: bus.rs_data = $urandom_range(1, 100);
            endcase
            case (k)
                1:       bus.op = BEQ;
                2:       bus.op = BNE;
                3:       bus.op = BLEZ;
                4:       bus.op = BGTZ;
                5:       bus.op = REGIMM;
                6:       bus.op = ($urandom_range(0, 1) == 0) ? J : JAL;
                7:       begin bus.op = SPECIAL; bus.func = ($urandom_range(0, 1) == 0) ? JR : JALR; end
                8:       bus.op = SPECIAL;
                default: bus.op = 6'b100011;
            endcase
            bus.branch      = (k >= 1 && k <= 5) && ($urandom_range(0, 7) != 0);
            bus.jump        = (k == 6);
            bus.instr_valid = ($urandom_range(0, 9) != 0);
            bus.imem_ready  = ($urandom_range(0, 4) != 0);
            bus.stall       = ($urandom_range(0, 4) == 0);
            bus.trap_req    = ($urandom_range(0, 24) == 0);

            seq = m_pc + 30'd1; tgt = seq; exp_taken = 0;
            off = int'($signed(bus.imm));
            if (!m_trap && bus.instr_valid && !m_pend) begin
                if (bus.op == SPECIAL && (bus.func == JR || bus.func == JALR)) begin
                    exp_taken = 1; tgt = bus.rs_data[31:2];
                end else if (bus.jump) begin
                    exp_taken = 1; tgt = {seq[29:26], bus.target};
                end else if (bus.branch) begin
                    case (bus.op)
                        BEQ:     cond = bus.zero;
                        BNE:     cond = !bus.zero;
                        BLEZ:    cond = $signed(bus.rs_data) <= 0;
                        BGTZ:    cond = $signed(bus.rs_data) > 0;
                        REGIMM:  cond = (bus.rt == BGEZ && $signed(bus.rs_data) >= 0) ||
                                        (bus.rt == BLTZ && $signed(bus.rs_data) < 0);
                        default: cond = 0;
                    endcase
                    if (cond) begin exp_taken = 1; tgt = seq + PC_W'(off); end
                end
            end
            #1;
            checks += 2;
            if (bus.taken !== exp_taken) begin
                errors++; $display("FAIL rnd_taken[%0d]: got %b want %b", i, bus.taken, exp_taken);
            end
            if (bus.link_pc !== m_pc + PC_W'(LINK_INC)) begin
                errors++; $display("FAIL rnd_link[%0d]: got %0h want %0h", i, bus.link_pc, m_pc + PC_W'(LINK_INC));
            end

            if (m_trap) begin
                m_trap = 0; m_pc = TVEC;
            end else if (bus.trap_req) begin
                m_trap = 1; m_epc_known = 1;
                m_epc = m_pend ? m_pend_bpc : m_pc;
                m_bd = m_pend; m_pend = 0;
            end else if (bus.instr_valid && bus.imem_ready && !bus.stall) begin
`ifdef PC_GEN_DELAY_SLOT_EN
                if (m_pend) begin
                    m_pc = m_pend_tgt; m_pend = 0;
                end else begin
                    if (exp_taken) begin m_pend = 1; m_pend_tgt = tgt; m_pend_bpc = m_pc; end
                    m_pc = seq;
                end
`else
                m_pc = tgt;
`endif
            end
            tick();
            checks += 4;
            if (bus.pc !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %0h want %0h", i, bus.pc, m_pc); end
            if (bus.pc_valid !== !m_trap) begin
                errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.pc_valid, !m_trap);
            end
            if (bus.trap_ack !== m_trap) begin
                errors++; $display("FAIL rnd_ack[%0d]: got %b want %b", i, bus.trap_ack, m_trap);
            end
            if (bus.epc_bd !== m_bd) begin
                errors++; $display("FAIL rnd_bd[%0d]: got %b want %b", i, bus.epc_bd, m_bd);
            end
            if (m_epc_known) begin
                checks++;
                if (bus.epc !== m_epc) begin
                    errors++; $display("FAIL rnd_epc[%0d]: got %0h want %0h", i, bus.epc, m_epc);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        idle();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks += 4;
        if (bus.pc !== '0) begin errors++; $display("FAIL arst_pc: got %0h want 0", bus.pc); end
        if (bus.pc_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b want 0", bus.pc_valid); end
        if (bus.epc !== '0) begin errors++; $display("FAIL arst_epc: got %0h want 0", bus.epc); end
        if (bus.trap_ack !== 1'b0) begin errors++; $display("FAIL arst_ack: got %b want 0", bus.trap_ack); end
        tick();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_beq();
        test_jr();
        test_stall();
        test_trap();
`ifdef PC_GEN_DELAY_SLOT_EN
        test_delay_slot();
`endif
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
